// File: rtl/uart_pkg.sv
// Shared types and constants for the UART 8N1 transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int UART_DEFAULT_DIV = 217;
  localparam int FRAME_BITS       = 10;
  // One start bit and one stop bit frame the payload.
  localparam int DATA_BITS        = FRAME_BITS - 2;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO with synchronous push/pop, registered count and head-of-queue read.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushOk;
  logic             popOk;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign level  = count_q;
  assign dout   = mem_q[rdPtr_q];
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;

  // Storage holds no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART 8N1 transmitter fed by a byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DIV_W       = 13,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DIV_W-1:0]       divisor,
  input  logic                   divisor_valid,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  uart_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [DIV_W-1:0] baudCnt_q, baudCnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] effDiv;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoDout;
  logic             pushEn;
  logic             popEn;

  assign wr_ready = !fifoFull;
  assign pushEn   = wr_valid && wr_ready;
  assign busy     = (state_q != IDLE) || !fifoEmpty;

  uart_byte_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pushEn),
    .pop  (popEn),
    .din  (wr_data),
    .dout (fifoDout),
    .full (fifoFull),
    .empty(fifoEmpty),
    .level(fifo_level)
  );

  // Divisors below 2 would collapse the bit counter, so they are raised to 2.
  always_comb begin
    effDiv = divisor_valid ? divisor : DIV_W'(DEFAULT_DIV);
    if (effDiv < DIV_W'(2)) begin
      effDiv = DIV_W'(2);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    baudCnt_d = baudCnt_q;
    div_d     = div_q;
    popEn     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          popEn     = 1'b1;
          shift_d   = fifoDout;
          div_d     = effDiv;
          baudCnt_d = effDiv - DIV_W'(1);
          state_d   = START;
        end
      end
      START: begin
        if (baudCnt_q == '0) begin
          state_d   = DATA;
          bitIdx_d  = '0;
          baudCnt_d = div_q - DIV_W'(1);
        end else begin
          baudCnt_d = baudCnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (baudCnt_q == '0) begin
          shift_d   = {1'b0, shift_q[7:1]};
          baudCnt_d = div_q - DIV_W'(1);
          if (bitIdx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        // A queued byte starts its start bit on the very next cycle, leaving no idle gap.
        if (baudCnt_q == '0) begin
          if (!fifoEmpty) begin
            popEn     = 1'b1;
            shift_d   = fifoDout;
            div_d     = effDiv;
            baudCnt_d = effDiv - DIV_W'(1);
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      baudCnt_q <= '0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitIdx_q  <= bitIdx_d;
      baudCnt_q <= baudCnt_d;
      div_q     <= div_d;
    end
  end

  // Decoded from registered state so an asynchronous reset returns the line high at once.
  always_comb begin
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed self-checking bench for uart_tx_fifo_ctrl with a background serial-line decoder.
module tb_uart_tx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [12:0] divisor;
  logic        divisor_valid;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   monDiv;
  int   monLocalDiv;
  int   monS;
  logic [9:0] monBits;
  bit   monAborted;
  int   startsSeen = 0;
  int   curStart = 0;
  logic [7:0] monByte[$];
  int   monStart[$];
  bit   monFrameOk[$];

  logic [7:0] stimQ[$];
  bit   readyLog[$];
  int   firstEdge;
  int   busyFallCyc = -1;
  bit   prevBusy = 1'b0;
  int   bad;
  int   startsBefore;
  int   waitCnt;

  uart_tx_fifo_ctrl #(
    .DEPTH(4),
    .DIV_W(13),
    .DEFAULT_DIV(217)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .divisor      (divisor),
    .divisor_valid(divisor_valid),
    .txd          (txd),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prevBusy && !busy) busyFallCyc = cyc;
    prevBusy = busy;
  end

  // Line decoder: samples each bit in its middle using the divisor the test expects for this frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && txd == 1'b0) begin
        monLocalDiv = monDiv;
        monS = cyc;
        curStart = cyc;
        startsSeen++;
        monAborted = 1'b0;
        monBits = '0;
        for (int k = 1; k < 10 * monLocalDiv; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            monAborted = 1'b1;
            break;
          end
          if (k % monLocalDiv == monLocalDiv / 2) monBits[4'(k / monLocalDiv)] = txd;
        end
        if (!monAborted) begin
          monByte.push_back(monBits[8:1]);
          monStart.push_back(monS);
          monFrameOk.push_back(monBits[0] == 1'b0 && monBits[9] == 1'b1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    readyLog.delete();
    @(negedge clk);
    firstEdge = cyc + 1;
    foreach (stimQ[i]) begin
      wr_data  = stimQ[i];
      wr_valid = 1'b1;
      readyLog.push_back(wr_ready);
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int k;
    k = 0;
    while (monByte.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frameCount", monByte.size(), n);
    repeat (5) @(negedge clk);
  endtask

  task automatic clearMon();
    monByte.delete();
    monStart.delete();
    monFrameOk.delete();
  endtask

  task automatic checkFrames(input string tag, input int div, input int firstStart);
    foreach (monByte[i]) begin
      checkOutput({tag, "_byte"}, 32'(monByte[i]), 32'(stimQ[i]));
      checkOutput({tag, "_framing"}, 32'(monFrameOk[i]), 32'd1);
      checkOutput({tag, "_start"}, monStart[i], firstStart + i * 10 * div);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    divisor = 13'd0;
    divisor_valid = 1'b0;
    monDiv = 217;

    #2;
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || fifo_level !== 3'd0) bad++;
    end
    checkOutput("idleHold", bad, 0);

    // Single byte at the default divisor.
    stimQ = '{8'h4F};
    applyStimulus();
    waitFrames(1, 3000);
    checkFrames("single", 217, firstEdge + 1);
    checkOutput("single_busyFall", busyFallCyc, firstEdge + 1 + 2170);
    clearMon();

    // "OK\n" written on consecutive cycles goes out with no idle gap.
    stimQ = '{8'h4F, 8'h4B, 8'h0A};
    applyStimulus();
    waitFrames(3, 7000);
    checkFrames("okNl", 217, firstEdge + 1);
    checkOutput("okNl_busyFall", busyFallCyc, firstEdge + 1 + 6510);
    clearMon();

    // Six writes into a four-entry FIFO: the sixth finds it full and is dropped.
    stimQ = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus();
    checkOutput("ovf_ready5", 32'(readyLog[4]), 32'd1);
    checkOutput("ovf_ready6", 32'(readyLog[5]), 32'd0);
    checkOutput("ovf_level", 32'(fifo_level), 32'd4);
    waitFrames(5, 11500);
    void'(stimQ.pop_back());
    checkFrames("ovf", 217, firstEdge + 1);
    checkOutput("ovf_busyFall", busyFallCyc, firstEdge + 1 + 10850);
    repeat (50) @(negedge clk);
    checkOutput("ovf_noSixth", monByte.size(), 5);
    clearMon();

    // Divisor changed mid-frame only affects the following frame.
    divisor = 13'd10;
    divisor_valid = 1'b1;
    monDiv = 10;
    stimQ = '{8'hA5, 8'h3C};
    applyStimulus();
    repeat (30) @(negedge clk);
    divisor = 13'd20;
    monDiv = 20;
    waitFrames(2, 500);
    checkOutput("div_byte0", 32'(monByte[0]), 32'hA5);
    checkOutput("div_byte1", 32'(monByte[1]), 32'h3C);
    checkOutput("div_start0", monStart[0], firstEdge + 1);
    checkOutput("div_frame1Len", monStart[1] - monStart[0], 100);
    checkOutput("div_busyFall", busyFallCyc, monStart[1] + 200);
    clearMon();

    // Divisors 1 and 0 are both treated as 2.
    divisor = 13'd1;
    monDiv = 2;
    stimQ = '{8'h96};
    applyStimulus();
    waitFrames(1, 100);
    checkFrames("div1", 2, firstEdge + 1);
    checkOutput("div1_busyFall", busyFallCyc, firstEdge + 1 + 20);
    clearMon();

    divisor = 13'd0;
    stimQ = '{8'h5A};
    applyStimulus();
    waitFrames(1, 100);
    checkFrames("div0", 2, firstEdge + 1);
    checkOutput("div0_busyFall", busyFallCyc, firstEdge + 1 + 20);
    clearMon();

    // Reset during data bit 3 (a zero bit of 0x55) must raise the line without a clock edge.
    divisor = 13'd10;
    monDiv = 10;
    stimQ = '{8'h55, 8'hAA};
    startsBefore = startsSeen;
    applyStimulus();
    waitCnt = 0;
    while (startsSeen == startsBefore && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstMid_started", 32'(startsSeen != startsBefore), 32'd1);
    waitCnt = 0;
    while (cyc < curStart + 45 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("rstMid_preTxd", 32'(txd), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstMid_txd", 32'(txd), 32'd1);
    checkOutput("rstMid_busy", 32'(busy), 32'd0);
    checkOutput("rstMid_level", 32'(fifo_level), 32'd0);
    checkOutput("rstMid_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("rstMid_quiet", bad, 0);
    checkOutput("rstMid_noFrame", monByte.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- UART 8N1 transmitter with a small byte FIFO.
- Sits between the CPU peripheral-bus write port and the chip UART pin (uo_out[0]).
- It is the upstream producer of the serial stream that the integration bench's UART monitor decodes ("OK\n", test result codes).
- Lets firmware queue several bytes and continue executing while the frames are sent back-to-back.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- DIV_W, 13: width of the baud divisor input.
- DEFAULT_DIV, 217: clocks per bit used while divisor_valid=0 (25 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  8  byte to transmit.
- wr_valid  in  1  write strobe, qualified by wr_ready.
- wr_ready  out  1  FIFO not full. Depends only on the registered count.
- divisor  in  DIV_W  clocks per bit.
- divisor_valid  in  1  1 = use divisor, 0 = use DEFAULT_DIV.
- txd  out  1  serial output, idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - txd=1, busy=0, fifo_level=0, wr_ready=1.
  - State=IDLE; pointers and counters cleared.
  - Reset mid-frame aborts the frame and forces txd=1 immediately, without waiting for a clock edge.
- Write acceptance:
  - A push occurs on a clock edge where wr_valid && wr_ready.
  - Writes while full are dropped, with no other side effect.
  - Push and pop in the same cycle: count unchanged.
  - Full + pop in the same cycle: the push is not accepted, because wr_ready was 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If count>0: pop the head into a shift register, latch the effective divisor, go to START.
  - txd=0 from that edge onward.
- START: txd=0 for div cycles, then go to DATA with bit_idx=0.
- DATA:
  - txd=shift[0] for div cycles, then shift right.
  - bit_idx increments; after bit_idx 7 completes, go to STOP. Bits go out LSB first.
- STOP: txd=1 for div cycles. At the end:
  - count>0: pop and go directly to START (zero idle gap).
  - Otherwise go to IDLE.
- Timing:
  - Every bit lasts exactly div clocks; a frame is exactly 10*div clocks.
  - Write accepted at edge N into an empty FIFO: txd falls at edge N+1.
- Divisor rules:
  - Latched at frame start. Changes mid-frame take effect on the next frame.
  - Effective divisor values 0 and 1 are clamped to 2.
- Bit counter: counts div-1 down to 0 and reloads; no wrap artefacts.
- busy = (state!=IDLE) || (count!=0).
- Pointers wrap modulo DEPTH. The count distinguishes full from empty.

Decomposition:
- Package uart_pkg holds:
  - State enum (IDLE/START/DATA/STOP).
  - DEFAULT_DIV.
  - Frame length constant (10 bits).
- One sub-module: uart_byte_fifo.
  - Synchronous push/pop, registered count.
  - Ports: push, pop, din, dout, full, empty, level.
- The top level holds the FSM, baud counter and shift register.

Test Plan:
- Reset, then hold idle 1000 cycles -> txd=1, busy=0, wr_ready=1, fifo_level=0 throughout.
- Write 0x4F at edge N, divisor_valid=0 -> txd falls at N+1; monitor sampling at 1.5/2.5/... bit times decodes 0x4F; stop bit high; busy drops at N+1+2170.
- Write "OK\n" (0x4F,0x4B,0x0A) on 3 consecutive cycles -> three frames, 6510 cycles total, no idle cycle between a stop bit and the next start bit, decoded bytes correct.
- DEPTH=4, wr_valid held high for 6 cycles with bytes 0x00-0x05 -> first 5 accepted (first popped immediately), wr_ready=0 on 6th cycle, 0x05 dropped; output 0x00-0x04 only.
- divisor=10, divisor_valid=1; change to 20 mid-frame -> current frame 100 cycles, next frame 200 cycles; divisor=1 -> bits last 2 cycles.
- Assert rst_n low during DATA bit 3 -> txd=1 immediately (asynchronously), FIFO emptied; after release, no residual frame is transmitted.
